// File: rtl/tex_quad_addr_gen.sv
// Pipelined texture address generator: one beat (point) or four beats (bilinear) per request.
// Optional request/stall counters are built when TEX_QUAD_ADDR_GEN_STATS_EN is defined.
`timescale 1ns/1ps
module tex_quad_addr_gen #(
   parameter int COORD_W = 16,
   parameter int FRAC_W  = 4,
   parameter int ADDR_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [COORD_W+FRAC_W-1:0] in_u,
   input  logic [COORD_W+FRAC_W-1:0] in_v,
   input  logic [63:0]               in_texMeta,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_W-1:0]         out_address,
   output logic [3:0]                out_xTexel,
   output logic [3:0]                out_yTexel,
   output logic [1:0]                out_idx,
   output logic                      out_last,
   output logic [FRAC_W-1:0]         out_fracU,
   output logic [FRAC_W-1:0]         out_fracV,
   output logic                      out_err,
   output logic [31:0]               stat_reqs,
   output logic [31:0]               stat_stalls
);
   localparam int UV_W = COORD_W + FRAC_W;
   // wide enough for x0+1 and for the mirror period 2*size at exp=15
   localparam int WW = (COORD_W + 2 > 17) ? COORD_W + 2 : 17;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q;
   logic                  out_valid_q, out_last_q, out_err_q;
   logic [1:0]            out_idx_q;
   logic [ADDR_W-1:0]     out_address_q;
   logic [3:0]            out_x_q, out_y_q;
   logic [FRAC_W-1:0]     out_fu_q, out_fv_q;
   logic signed [WW-1:0]  x0_q, y0_q;
   logic [4:0]            fmt_q;
   logic [3:0]            we_q, he_q;
   logic [1:0]            wu_q, wv_q;
   logic                  bil_q;
   logic [ADDR_W-1:0]     base_q;

   logic signed [COORD_W-1:0] u_int, v_int;
   logic                  idle, load;
   logic signed [WW-1:0]  sx0, sy0, cx, cy;
   logic [4:0]            sfmt;
   logic [3:0]            swe, she;
   logic [1:0]            swu, swv, nidx;
   logic                  sbil, last_d;
   logic [ADDR_W-1:0]     sbase, addr_d;
   logic [15:0]           wx, wy;
   logic [ADDR_W:0]       off;
   logic                  unused_meta;

   function automatic logic [15:0] wrap_c(input logic signed [WW-1:0] c,
                                          input logic [3:0] e,
                                          input logic [1:0] m);
      logic signed [WW-1:0] sz, mk, r;
      sz = WW'(1) << e;
      mk = c & ((sz <<< 1) - WW'(1));
      unique case (m)
         2'b01:   r = c[WW-1] ? '0 : (c >= sz) ? sz - WW'(1) : c;
         2'b10:   r = (mk < sz) ? mk : (sz <<< 1) - WW'(1) - mk;
         default: r = c & (sz - WW'(1));
      endcase
      return r[15:0];
   endfunction

   function automatic logic [ADDR_W:0] rel_off(input logic [15:0] x,
                                               input logic [15:0] y,
                                               input logic [4:0]  f,
                                               input logic [3:0]  we);
      logic [ADDR_W-1:0] lin, cmp, til, o;
      logic [3:0]        cs, ts;
      logic [4:0]        sc;
      logic              er;
      cs  = (we >= 4'd2) ? we - 4'd2 : 4'd0;
      ts  = (we >= 4'd4) ? we - 4'd4 : 4'd0;
      lin = (ADDR_W'(y) << we) + ADDR_W'(x);
      cmp = (ADDR_W'(y >> 2) << cs) | ADDR_W'(x >> 2);
      til = (((ADDR_W'(y >> 4) << ts) | ADDR_W'(x >> 4)) << 8)
          | ADDR_W'({y[3:0], x[3:0]});
      o   = lin;
      sc  = 5'd0;
      er  = 1'b0;
      unique casez (f)
         5'b00000: sc = 5'd3;
         5'b00100: sc = 5'd4;
         5'b???01: sc = 5'd2;
         5'b00010: begin o = cmp; sc = 5'd8;  end
         5'b10010: begin o = cmp; sc = 5'd8;  end
         5'b00110: begin o = cmp; sc = 5'd16; end
         5'b00011: begin o = til; sc = 5'd3;  end
         5'b00111: begin o = til; sc = 5'd4;  end
         5'b01011: begin o = til; sc = 5'd2;  end
         5'b01111: begin o = til; sc = 5'd2;  end
         5'b10011: begin o = til; sc = 5'd1;  end
         5'b10111: begin o = til; sc = 5'd2;  end
         default:  er = 1'b1;
      endcase
      return {er, o * ADDR_W'(sc)};
   endfunction

   assign unused_meta = ^in_texMeta[31:18];
   assign u_int = in_u[UV_W-1:FRAC_W];
   assign v_int = in_v[UV_W-1:FRAC_W];
   assign idle  = (state_q == IDLE);
   assign in_ready = idle;

   // beat 0 is computed straight from the request port, later beats from the capture
   always_comb begin
      if (idle) begin
         sx0   = WW'(u_int);
         sy0   = WW'(v_int);
         sfmt  = in_texMeta[4:0];
         she   = in_texMeta[8:5];
         swe   = in_texMeta[12:9];
         swu   = in_texMeta[14:13];
         swv   = in_texMeta[16:15];
         sbil  = in_texMeta[17];
         sbase = ADDR_W'(in_texMeta[63:32]);
      end else begin
         sx0   = x0_q;
         sy0   = y0_q;
         sfmt  = fmt_q;
         she   = he_q;
         swe   = we_q;
         swu   = wu_q;
         swv   = wv_q;
         sbil  = bil_q;
         sbase = base_q;
      end
   end

   assign nidx   = idle ? 2'd0 : out_idx_q + 2'd1;
   assign cx     = sx0 + WW'(nidx[0]);
   assign cy     = sy0 + WW'(nidx[1]);
   assign wx     = wrap_c(cx, swe, swu);
   assign wy     = wrap_c(cy, she, swv);
   assign off    = rel_off(wx, wy, sfmt, swe);
   assign addr_d = sbase + off[ADDR_W-1:0];
   assign last_d = !sbil || (nidx == 2'd3);
   assign load   = idle ? in_valid : (out_ready && !out_last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_err_q     <= 1'b0;
         out_idx_q     <= '0;
         out_address_q <= '0;
         out_x_q       <= '0;
         out_y_q       <= '0;
         out_fu_q      <= '0;
         out_fv_q      <= '0;
         x0_q          <= '0;
         y0_q          <= '0;
         fmt_q         <= '0;
         we_q          <= '0;
         he_q          <= '0;
         wu_q          <= '0;
         wv_q          <= '0;
         bil_q         <= 1'b0;
         base_q        <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (in_valid) begin
               x0_q        <= sx0;
               y0_q        <= sy0;
               fmt_q       <= sfmt;
               we_q        <= swe;
               he_q        <= she;
               wu_q        <= swu;
               wv_q        <= swv;
               bil_q       <= sbil;
               base_q      <= sbase;
               out_fu_q    <= in_u[FRAC_W-1:0];
               out_fv_q    <= in_v[FRAC_W-1:0];
               out_valid_q <= 1'b1;
               state_q     <= ISSUE;
            end
            ISSUE: if (out_ready && out_last_q) begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
         if (load) begin
            out_address_q <= addr_d;
            out_x_q       <= wx[3:0];
            out_y_q       <= wy[3:0];
            out_idx_q     <= nidx;
            out_last_q    <= last_d;
            out_err_q     <= off[ADDR_W];
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_address = out_address_q;
   assign out_xTexel  = out_x_q;
   assign out_yTexel  = out_y_q;
   assign out_idx     = out_idx_q;
   assign out_last    = out_last_q;
   assign out_fracU   = out_fu_q;
   assign out_fracV   = out_fv_q;
   assign out_err     = out_err_q;

`ifdef TEX_QUAD_ADDR_GEN_STATS_EN
   logic [31:0] reqs_q, stalls_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reqs_q   <= '0;
         stalls_q <= '0;
      end else begin
         if (in_valid && idle)
            reqs_q <= reqs_q + 32'd1;
         if (out_valid_q && !out_ready)
            stalls_q <= stalls_q + 32'd1;
      end
   end

   assign stat_reqs   = reqs_q;
   assign stat_stalls = stalls_q;
`else
   assign stat_reqs   = '0;
   assign stat_stalls = '0;
`endif

endmodule
